serial_shift_unit: RTL and testbench

//   Multi-cycle shifter that consumes the 5-bit shift amount chosen by the

---
 rtl/serial_shift_unit.sv | 120 ++++++++++++
 tb/tb_serial_shift_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter with a start/done handshake; busy stalls the pipeline.
// Optional build macro SHIFT_MULTI_STEP_EN: shift by 4 per cycle while at least 4 bits remain.
module serial_shift_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_start_1,
    input  logic [1:0]             in_op_2,
    input  logic [DATA_WIDTH-1:0]  in_data_32,
    input  logic [SHAMT_WIDTH-1:0] in_shamt_5,
    output logic                   out_busy_1,
    output logic                   out_done_1,
    output logic [DATA_WIDTH-1:0]  out_result_32
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam logic [SHAMT_WIDTH-1:0] ONE = SHAMT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [DATA_WIDTH-1:0]  result_reg, result_next;
    logic [SHAMT_WIDTH-1:0] count_reg, count_next;
    logic [1:0]             op_reg, op_next;
    logic [DATA_WIDTH-1:0]  shift1;

    always_comb begin
        shift1 = result_reg;
        case (op_reg)
            OP_SLL:  shift1 = {result_reg[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  shift1 = {1'b0, result_reg[DATA_WIDTH-1:1]};
            OP_SRA:  shift1 = {result_reg[DATA_WIDTH-1], result_reg[DATA_WIDTH-1:1]};
            default: shift1 = result_reg;
        endcase
    end

`ifdef SHIFT_MULTI_STEP_EN
    localparam logic [SHAMT_WIDTH-1:0] FOUR = SHAMT_WIDTH'(4);
    logic [DATA_WIDTH-1:0] shift4;

    always_comb begin
        shift4 = result_reg;
        case (op_reg)
            OP_SLL:  shift4 = {result_reg[DATA_WIDTH-5:0], 4'b0000};
            OP_SRL:  shift4 = {4'b0000, result_reg[DATA_WIDTH-1:4]};
            OP_SRA:  shift4 = {{4{result_reg[DATA_WIDTH-1]}}, result_reg[DATA_WIDTH-1:4]};
            default: shift4 = result_reg;
        endcase
    end
`endif

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        count_next  = count_reg;
        op_next     = op_reg;
        case (state_reg)
            IDLE: begin
                if (in_start_1) begin
                    result_next = in_data_32;
                    op_next     = in_op_2;
                    count_next  = in_shamt_5;
                    // Reserved op behaves as a zero-length shift: operand passes through.
                    if (in_op_2 == OP_RSV || in_shamt_5 == '0) begin
                        count_next = '0;
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
`ifdef SHIFT_MULTI_STEP_EN
                if (count_reg >= FOUR) begin
                    result_next = shift4;
                    count_next  = count_reg - FOUR;
                end else begin
                    result_next = shift1;
                    count_next  = count_reg - ONE;
                end
                if (count_next == '0) begin
                    state_next = DONE;
                end
`else
                result_next = shift1;
                count_next  = count_reg - ONE;
                if (count_reg == ONE) begin
                    state_next = DONE;
                end
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            count_reg  <= '0;
            op_reg     <= 2'b00;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            count_reg  <= count_next;
            op_reg     <= op_next;
        end
    end

    assign out_busy_1    = (state_reg != IDLE);
    assign out_done_1    = (state_reg == DONE);
    assign out_result_32 = result_reg;

endmodule

// File: tb/tb_serial_shift_unit.sv
// Self-checking bench for serial_shift_unit: vector table plus reset/restart corner sequences,
// with expected results queued at start and popped when done is seen.
module tb_serial_shift_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_start_1;
    logic [1:0]  in_op_2;
    logic [31:0] in_data_32;
    logic [4:0]  in_shamt_5;
    logic        out_busy_1;
    logic        out_done_1;
    logic [31:0] out_result_32;

    serial_shift_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_start_1    (in_start_1),
        .in_op_2       (in_op_2),
        .in_data_32    (in_data_32),
        .in_shamt_5    (in_shamt_5),
        .out_busy_1    (out_busy_1),
        .out_done_1    (out_done_1),
        .out_result_32 (out_result_32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] result;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input int s);
        if (op == 2'b11) return 1;
`ifdef SHIFT_MULTI_STEP_EN
        return s / 4 + s % 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    // Runs one transaction; restart_cyc > 0 pulses a second start at that cycle.
    task automatic run_txn(input string tag, input logic [1:0] op, input logic [31:0] data,
                           input logic [4:0] shamt, input logic [31:0] exp_res, input int restart_cyc);
        exp_t        e;
        int          cyc;
        logic        busy_ok;
        int          extra;
        logic [31:0] held;
        @(negedge clk);
        in_op_2 = op; in_data_32 = data; in_shamt_5 = shamt; in_start_1 = 1'b1;
        e.result = exp_res;
        e.lat    = exp_lat(op, int'(shamt));
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_start_1 = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!out_done_1 && cyc < 100) begin
            if (!out_busy_1) busy_ok = 1'b0;
            if (cyc == restart_cyc) begin
                @(negedge clk);
                in_start_1 = 1'b1; in_data_32 = ~data; in_op_2 = 2'b00; in_shamt_5 = 5'd1;
            end
            @(posedge clk); #1;
            in_start_1 = 1'b0;
            cyc++;
        end
        if (!out_done_1) begin
            check({tag, " timeout_done"}, {31'b0, out_done_1}, 32'd1);
            void'(sb_q.pop_front());
            return;
        end
        if (!out_busy_1) busy_ok = 1'b0;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, " result"}, out_result_32, e.result);
        check({tag, " latency"}, 32'(cyc), 32'(e.lat));
        check({tag, " busy_while_active"}, {31'b0, busy_ok}, 32'd1);
        held  = out_result_32;
        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_done_1 || out_busy_1 || out_result_32 !== held) extra++;
        end
        check({tag, " idle_after_done"}, 32'(extra), 32'd0);
        $display("txn %-12s op=%0d data=0x%08h shamt=%0d -> result=0x%08h latency=%0d",
                 tag, op, data, shamt, out_result_32, cyc);
    endtask

    vec_t vecs[12];

    initial begin
        int dcnt;
        vecs[0]  = '{2'b00, 32'h00000001, 5'd5,  32'h00000020};
        vecs[1]  = '{2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF};
        vecs[2]  = '{2'b01, 32'h80000000, 5'd31, 32'h00000001};
        vecs[3]  = '{2'b01, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
        vecs[4]  = '{2'b11, 32'hDEADBEEF, 5'd7,  32'hDEADBEEF};
        vecs[5]  = '{2'b00, 32'h00000001, 5'd9,  32'h00000200};
        vecs[6]  = '{2'b10, 32'h7FFFFFFF, 5'd31, 32'h00000000};
        vecs[7]  = '{2'b10, 32'hF0F0F0F0, 5'd3,  32'hFE1E1E1E};
        vecs[8]  = '{2'b01, 32'hF0F0F0F0, 5'd3,  32'h1E1E1E1E};
        vecs[9]  = '{2'b00, 32'hFFFFFFFF, 5'd31, 32'h80000000};
        vecs[10] = '{2'b10, 32'h80000000, 5'd4,  32'hF8000000};
        vecs[11] = '{2'b00, 32'h12345678, 5'd8,  32'h34567800};

        reset = 1'b1; in_start_1 = 1'b0; in_op_2 = 2'b00; in_data_32 = '0; in_shamt_5 = '0;
        #1;
        check("reset busy",   {31'b0, out_busy_1}, 32'd0);
        check("reset done",   {31'b0, out_done_1}, 32'd0);
        check("reset result", out_result_32, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].result, 0);

        // Second start during SHIFT must be dropped.
        run_txn("restart", 2'b01, 32'hF0000000, 5'd4, 32'h0F000000, 1);

        // Asynchronous reset in the middle of a 10-bit shift.
        @(negedge clk);
        in_op_2 = 2'b00; in_data_32 = 32'h00000003; in_shamt_5 = 5'd10; in_start_1 = 1'b1;
        @(posedge clk); #1;
        in_start_1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midshift busy_before_reset", {31'b0, out_busy_1}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midshift reset busy",   {31'b0, out_busy_1}, 32'd0);
        check("midshift reset done",   {31'b0, out_done_1}, 32'd0);
        check("midshift reset result", out_result_32, 32'd0);
        #2 reset = 1'b0;
        dcnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_done_1 || out_busy_1) dcnt++;
        end
        check("midshift no_done_after_abort", 32'(dcnt), 32'd0);
        $display("txn %-12s reset aborted SLL 0x00000003 by 10; activity_after=%0d", "abort", dcnt);
        run_txn("after_reset", 2'b00, 32'h00000003, 5'd10, 32'h00000C00, 0);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
